eit_frame_assembler: RTL and testbench

EIT_FRAME_ASSEMBLER -- requirements
Module: eit_frame_assembler

---
 rtl/eit_frame_assembler.sv | 192 +++++++++++++++++++
 tb/tb_eit_frame_assembler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/eit_frame_assembler.sv
// EIT frame assembler: averages ADC samples per enabled channel for each excitation
// step, then queues the averages in ascending channel order into a fall-through FIFO.
module eit_frame_assembler #(
    parameter int NUM_STEPS  = 16,
    parameter int AVG_LOG2   = 2,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        abort,
    input  logic [7:0]  channel_mask,
    input  logic [2:0]  sample_channel,
    input  logic [15:0] sample_data,
    input  logic        sample_valid,
    input  logic        adc_error,
    output logic [15:0] out_data,
    output logic [3:0]  out_step,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        step_done,
    output logic        busy,
    output logic        sample_dropped,
    output logic        frame_error
);
    localparam int ACC_W = 16 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(1 << AVG_LOG2);
    localparam logic [CNT_W-1:0] CNT_ALMOST = CNT_W'((1 << AVG_LOG2) - 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W:0] FIFO_FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [3:0] LAST_STEP = 4'(NUM_STEPS - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;
    state_t state_reg, state_next;

    logic [7:0]         mask_reg;
    logic [7:0]         drained_reg;
    logic [3:0]         step_reg;
    logic               step_done_reg;
    logic               sample_dropped_reg;
    logic               frame_error_reg;
    logic [20:0]        fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg;
    logic [PTR_W:0]     count_reg;

    logic [8*ACC_W-1:0] acc_flat;
    logic [7:0]         cnt_full, cnt_almost, full_next;
    logic               start_ok, start_bad, accept, step_complete;
    logic [7:0]         pending;
    logic [2:0]         drain_ch;
    logic               last_word, fifo_full, fifo_empty, push, pop, end_of_step;
    logic signed [ACC_W-1:0] drain_acc, drain_shifted;
    logic [20:0]        push_word, head_word;

    assign start_ok  = (state_reg == IDLE) && frame_start && !abort && (channel_mask != 8'h00);
    assign start_bad = (state_reg == IDLE) && frame_start && !abort && (channel_mask == 8'h00);
    assign accept    = (state_reg == COLLECT) && sample_valid && mask_reg[sample_channel]
                       && !cnt_full[sample_channel];

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ch
            logic signed [ACC_W-1:0] acc_reg;
            logic [CNT_W-1:0]        cnt_reg;
            logic                    hit;

            assign hit = accept && (sample_channel == 3'(gi));

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    acc_reg <= '0;
                    cnt_reg <= '0;
                end else if (abort || start_ok || end_of_step) begin
                    acc_reg <= '0;
                    cnt_reg <= '0;
                end else if (hit) begin
                    acc_reg <= acc_reg + ACC_W'(signed'(sample_data));
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end

            assign acc_flat[gi*ACC_W +: ACC_W] = acc_reg;
            assign cnt_full[gi]   = (cnt_reg == CNT_FULL);
            assign cnt_almost[gi] = (cnt_reg == CNT_ALMOST);
            assign full_next[gi]  = cnt_full[gi] | (hit & cnt_almost[gi]);
        end
    endgenerate

    // The step is complete once every enabled channel is full, counting this cycle's sample.
    assign step_complete = (state_reg == COLLECT) && (&(full_next | ~mask_reg));

    assign pending = mask_reg & ~drained_reg;

    always_comb begin
        drain_ch = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) drain_ch = 3'(i);
        end
    end

    assign last_word     = ((pending & (pending - 8'd1)) == 8'h00);
    assign fifo_full     = (count_reg == FIFO_FULL_CNT);
    assign fifo_empty    = (count_reg == '0);
    assign pop           = !fifo_empty && out_ready && !abort;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign push          = (state_reg == DRAIN) && !abort && (!fifo_full || pop);
    assign end_of_step   = push && last_word;
    assign drain_acc     = acc_flat[int'(drain_ch)*ACC_W +: ACC_W];
    assign drain_shifted = drain_acc >>> AVG_LOG2;
    assign push_word     = {last_word && (step_reg == LAST_STEP), step_reg, drain_shifted[15:0]};

    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (start_ok) state_next = COLLECT;
                COLLECT: if (step_complete) state_next = DRAIN;
                DRAIN:   if (end_of_step) state_next = (step_reg == LAST_STEP) ? IDLE : COLLECT;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg          <= IDLE;
            mask_reg           <= 8'h00;
            drained_reg        <= 8'h00;
            step_reg           <= 4'd0;
            step_done_reg      <= 1'b0;
            sample_dropped_reg <= 1'b0;
            frame_error_reg    <= 1'b0;
        end else begin
            state_reg     <= state_next;
            step_done_reg <= end_of_step;
            if (start_ok) mask_reg <= channel_mask;

            if (abort || start_ok || end_of_step) drained_reg <= 8'h00;
            else if (push)                        drained_reg[drain_ch] <= 1'b1;

            if (abort || start_ok)   step_reg <= 4'd0;
            else if (end_of_step)    step_reg <= (step_reg == LAST_STEP) ? 4'd0 : step_reg + 4'd1;

            if (sample_valid && (state_reg != COLLECT)) sample_dropped_reg <= 1'b1;
            else if (start_ok || start_bad)             sample_dropped_reg <= 1'b0;

            if (start_bad)                                frame_error_reg <= 1'b1;
            else if (start_ok)                            frame_error_reg <= 1'b0;
            else if (adc_error && (state_reg != IDLE))    frame_error_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr_reg] <= push_word;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (abort) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Head word is masked while empty so the outputs read zero after reset or flush.
    assign head_word      = fifo_empty ? 21'd0 : fifo_mem[rd_ptr_reg];
    assign out_data       = head_word[15:0];
    assign out_step       = head_word[19:16];
    assign out_last       = head_word[20];
    assign out_valid      = !fifo_empty;
    assign step_done      = step_done_reg;
    assign busy           = (state_reg != IDLE);
    assign sample_dropped = sample_dropped_reg;
    assign frame_error    = frame_error_reg;

endmodule

// File: tb/tb_eit_frame_assembler.sv
// Directed bench for eit_frame_assembler: averaging, full frame, backpressure,
// dropped/ignored samples, error flags, abort and asynchronous reset.
module tb_eit_frame_assembler;
    logic        clk = 1'b0;
    logic        reset_n, frame_start, abort, sample_valid, adc_error, out_ready;
    logic [7:0]  channel_mask;
    logic [2:0]  sample_channel;
    logic [15:0] sample_data;
    logic [15:0] out_data;
    logic [3:0]  out_step;
    logic        out_last, out_valid, step_done, busy, sample_dropped, frame_error;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    logic [20:0] got [$];

    always #5 clk = ~clk;

    eit_frame_assembler dut (
        .clk(clk), .reset_n(reset_n), .frame_start(frame_start), .abort(abort),
        .channel_mask(channel_mask), .sample_channel(sample_channel),
        .sample_data(sample_data), .sample_valid(sample_valid), .adc_error(adc_error),
        .out_data(out_data), .out_step(out_step), .out_last(out_last),
        .out_valid(out_valid), .out_ready(out_ready), .step_done(step_done),
        .busy(busy), .sample_dropped(sample_dropped), .frame_error(frame_error)
    );

    // Record transfers and step_done pulses halfway between active edges.
    always @(negedge clk) begin
        if (reset_n) begin
            if (out_valid && out_ready) got.push_back({out_last, out_step, out_data});
            if (step_done) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input int ch, input int val);
        sample_channel = 3'(ch);
        sample_data    = 16'(val);
        sample_valid   = 1'b1;
        tick();
        sample_valid   = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] m);
        channel_mask = m;
        frame_start  = 1'b1;
        tick();
        frame_start  = 1'b0;
    endtask

    task automatic wait_step_done(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (step_done) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    // Samples v..v+3 sum to 4v+6, so the floored average is v+1 (also for negative v).
    function automatic logic [15:0] avg_word(input int s, input int c);
        return 16'(s * 256 + c * 8 - 499);
    endfunction

    task automatic send_step(input int s);
        for (int k = 0; k < 4; k++)
            for (int c = 0; c < 8; c++)
                send(c, s * 256 + c * 8 - 500 + k);
    endtask

    initial begin
        int base, dbase, s, c;
        logic [20:0] expw;
        reset_n = 1'b0; frame_start = 1'b0; abort = 1'b0; sample_valid = 1'b0;
        adc_error = 1'b0; out_ready = 1'b1; channel_mask = 8'h00;
        sample_channel = 3'd0; sample_data = 16'h0000;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_flags", 32'({out_last, step_done, sample_dropped, frame_error, out_step}), 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        tick();

        // Averaging with mask 03
        base = got.size(); dbase = done_cnt;
        start_frame(8'h03);
        chk("avg_busy", 32'(busy), 32'd1);
        send(0, 100); send(1, -1); send(0, 102); send(1, -2);
        send(0, 104); send(1, -3); send(0, 106); send(1, -4);
        wait_step_done("avg_step_done");
        repeat (3) tick();
        chk("avg_words", 32'(got.size() - base), 32'd2);
        chk("avg_w0", 32'(got[base]), 32'({1'b0, 4'd0, 16'd103}));
        chk("avg_w1", 32'(got[base+1]), 32'({1'b0, 4'd0, 16'hFFFD}));
        chk("avg_done_cnt", 32'(done_cnt - dbase), 32'd1);

        // Step 1: masked channel, over-full channel, then a sample during DRAIN
        send(5, 7);
        repeat (4) send(0, 8);
        send(0, 1000);
        send(1, -8); send(1, -8); send(1, -8);
        chk("masked_no_flag", 32'(sample_dropped), 32'd0);
        send(1, -8);
        chk("drain_state_busy", 32'(busy), 32'd1);
        send(2, 55);
        wait_step_done("s1_step_done");
        repeat (3) tick();
        chk("drop_flag", 32'(sample_dropped), 32'd1);
        chk("s1_w0", 32'(got[base+2]), 32'({1'b0, 4'd1, 16'd8}));
        chk("s1_w1", 32'(got[base+3]), 32'({1'b0, 4'd1, 16'hFFF8}));
        abort = 1'b1; tick(); abort = 1'b0;
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_sticky", 32'(sample_dropped), 32'd1);

        // Empty mask
        start_frame(8'h00);
        chk("mask0_idle", 32'(busy), 32'd0);
        chk("mask0_err", 32'(frame_error), 32'd1);

        // Full frame, adc_error pulse in step 5
        base = got.size(); dbase = done_cnt;
        start_frame(8'hFF);
        chk("ff_err_clr", 32'(frame_error), 32'd0);
        chk("ff_drop_clr", 32'(sample_dropped), 32'd0);
        for (int st = 0; st < 16; st++) begin
            if (st == 5) begin
                adc_error = 1'b1; tick(); adc_error = 1'b0;
            end
            send_step(st);
            wait_step_done("ff_step_done");
        end
        repeat (4) tick();
        chk("ff_words", 32'(got.size() - base), 32'd128);
        chk("ff_done_cnt", 32'(done_cnt - dbase), 32'd16);
        chk("ff_busy_low", 32'(busy), 32'd0);
        chk("ff_adc_err", 32'(frame_error), 32'd1);
        for (int i = 0; i < 128 && (base + i) < got.size(); i++) begin
            s = i / 8; c = i % 8;
            expw = {(i == 127), 4'(s), avg_word(s, c)};
            chk("ff_word", 32'(got[base+i]), 32'(expw));
        end

        // Backpressure over 3 steps
        base = got.size(); dbase = done_cnt;
        out_ready = 1'b0;
        start_frame(8'hFF);
        send_step(0); wait_step_done("bp_s0_done");
        send_step(1); wait_step_done("bp_s1_done");
        send_step(2);
        repeat (10) tick();
        chk("bp_stall_busy", 32'(busy), 32'd1);
        chk("bp_stall_done", 32'(done_cnt - dbase), 32'd2);
        chk("bp_head", 32'({out_valid, out_last, out_step, out_data}),
            32'({1'b1, 1'b0, 4'd0, avg_word(0, 0)}));
        out_ready = 1'b1;
        wait_step_done("bp_s2_done");
        repeat (20) tick();
        chk("bp_words", 32'(got.size() - base), 32'd24);
        for (int i = 0; i < 24 && (base + i) < got.size(); i++) begin
            expw = {1'b0, 4'(i / 8), avg_word(i / 8, i % 8)};
            chk("bp_word", 32'(got[base+i]), 32'(expw));
        end

        // Abort during DRAIN with FIFO non-empty
        out_ready = 1'b0;
        send_step(3);
        repeat (3) tick();
        chk("ab_pre_valid", 32'(out_valid), 32'd1);
        chk("ab_pre_busy", 32'(busy), 32'd1);
        abort = 1'b1; tick(); abort = 1'b0;
        chk("ab_valid", 32'(out_valid), 32'd0);
        chk("ab_busy", 32'(busy), 32'd0);

        // Reset mid-frame with flags set and FIFO non-empty
        start_frame(8'hFF);
        send_step(0);
        adc_error = 1'b1;
        send(3, 9);
        adc_error = 1'b0;
        repeat (2) tick();
        chk("mid_flags", 32'({sample_dropped, frame_error, out_valid, busy}), 32'hF);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_flags", 32'({out_last, step_done, sample_dropped, frame_error, out_step}), 32'd0);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
